// File: rtl/fill_expander_pkg.sv
// Shared types for the fill token decoder: fill classes, sequencer states
// and the token record as it appears on the upstream interface.
package fill_expander_pkg;

    localparam int TOK_LW = 4;
    localparam int TOK_CW = 4;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_ONES = 2'd1,
        FILL_ZEXT = 2'd2,
        FILL_SEXT = 2'd3
    } fill_kind_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    typedef struct packed {
        fill_kind_e          kind;
        logic [TOK_CW-1:0]   count;
        logic [TOK_LW-1:0]   data;
    } fill_token_t;

endpackage

// File: rtl/fill_word_expand.sv
// Combinational reconstruction of a full-width word from a fill class and
// literal payload; also used by the compressor's self-check path.
module fill_word_expand
    import fill_expander_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LW    = 4
) (
    input  fill_kind_e        kind,
    input  logic [LW-1:0]     data,
    output logic [WIDTH-1:0]  word
);

    // Size casts do the extension, so WIDTH == LW needs no special case.
    always_comb begin
        word = '0;
        unique case (kind)
            FILL_ZERO: word = '0;
            FILL_ONES: word = '1;
            FILL_ZEXT: word = WIDTH'(data);
            FILL_SEXT: word = WIDTH'($signed(data));
            default:   word = '0;
        endcase
    end

endmodule

// File: rtl/fill_expander.sv
// Streaming decoder: each accepted fill token becomes count+1 identical
// output words, with back-to-back token acceptance on the final word.
module fill_expander
    import fill_expander_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LW    = 4,
    parameter int CW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [CW-1:0]     in_count,
    input  logic [LW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and out_valid never depends on in_valid.

    state_e             state, state_next;
    logic [CW-1:0]      remaining, remaining_next;
    logic [WIDTH-1:0]   word, data_next;
    logic               last_next;
    logic               accept;

    fill_word_expand #(
        .WIDTH (WIDTH),
        .LW    (LW)
    ) u_expand (
        .kind (fill_kind_e'(in_kind)),
        .data (in_data),
        .word (word)
    );

    assign out_valid = (state == ST_EMIT);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        data_next      = out_data;
        last_next      = out_last;
        in_ready       = 1'b0;
        unique case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_EMIT: in_ready = out_ready && (remaining == '0);
            default: in_ready = 1'b0;
        endcase
        // A token load looks the same whether it comes from IDLE or the last beat.
        if (accept) begin
            data_next      = word;
            remaining_next = in_count;
            last_next      = (in_count == '0);
            state_next     = ST_EMIT;
        end else if (state == ST_EMIT && out_ready) begin
            if (remaining != '0) begin
                remaining_next = remaining - 1'b1;
                last_next      = (remaining == CW'(1));
            end else begin
                last_next  = 1'b0;
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            out_data  <= data_next;
            out_last  <= last_next;
        end
    end

endmodule

// File: doc/fill_expander.md
Name: fill_expander

Overview:
- Streaming decoder that expands compact fill tokens into full-width words.
- A token names a fill class and a repeat count. Classes: all-zeros ('0), all-ones ('1), zero-extended literal, sign-extended literal.
- Inverse of the fill-generation/compare logic: that side reduces words to fill classes; this block reconstitutes the words.
- Sits between a token FIFO upstream and a word consumer downstream, with valid/ready on both sides.

Parameters:
- WIDTH, 8, output word width in bits (>= LW).
- LW, 4, literal payload width in bits.
- CW, 4, repeat-count width; a token emits count+1 words (1..2^CW).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  token offered.
- in_ready  output  1  token accepted when in_valid && in_ready.
- in_kind  input  2  0=ZERO, 1=ONES, 2=ZEXT, 3=SEXT.
- in_count  input  CW  repeat count minus one.
- in_data  input  LW  literal; ignored for ZERO and ONES.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_data  output  WIDTH  expanded word.
- out_last  output  1  marks the final word of the current token.

Behaviour:
- Reset (async assert, sync-safe deassert) drives state IDLE, out_valid=0, out_data=0, out_last=0, remaining=0. in_ready follows from state, so it reads 1 after reset.
- State machine has two states: IDLE and EMIT.
- IDLE:
  - in_ready=1.
  - On token accept: latch word = expand(kind, data) into out_data, remaining=in_count, out_last=(in_count==0), out_valid=1, go to EMIT.
  - Latency from token accept to first word valid is exactly 1 cycle.
- Expansion rules:
  - ZERO: all WIDTH bits 0.
  - ONES: all WIDTH bits 1.
  - ZEXT: in_data in the LSBs, upper WIDTH-LW bits 0.
  - SEXT: in_data in the LSBs, upper bits replicate in_data[LW-1].
  - When WIDTH==LW, ZEXT and SEXT both pass in_data unchanged.
- EMIT, no beat this cycle (out_valid && !out_ready): out_data, out_last and remaining hold stable. No output change while stalled.
- EMIT, beat with remaining>0: remaining decrements; out_data is unchanged (same word repeated); out_last=(remaining==1).
- EMIT, beat with remaining==0 (the last word):
  - in_ready=1 combinationally this cycle.
  - If a token is accepted in the same cycle, load it exactly as from IDLE and stay in EMIT. This gives back-to-back tokens with no bubble.
  - Otherwise: out_valid=0, out_last=0, go to IDLE.
- In EMIT, in_ready=0 except on the last-word beat. in_ready may depend combinationally on out_ready; out_valid must not depend combinationally on in_valid.
- Throughput is 1 word per cycle when out_ready is held high; every token costs exactly count+1 output beats.
- Max count (all ones) emits 2^CW words. The remaining counter never wraps: it decrements only while >0.
- Reset asserted mid-token abandons the token immediately; no partial words are emitted after rst_n deasserts.
- out_data holds its last value while out_valid=0; the consumer must ignore it. The bench checks it only when out_valid=1.

Decomposition:
- Package fill_expander_pkg:
  - enum fill_kind_e {FILL_ZERO, FILL_ONES, FILL_ZEXT, FILL_SEXT} (2-bit).
  - enum state_e {ST_IDLE, ST_EMIT}.
  - struct fill_token_t {kind, count, data}.
- One combinational sub-module, fill_word_expand (kind, data -> WIDTH-bit word). It is reused by the future compressor's self-check.
- Sequencing, counter and handshake stay in fill_expander.

Test Plan (WIDTH=8, LW=4, CW=4):
- Reset then token {ONES, count=2} with out_ready=1 -> in_ready=1 after reset; out_valid rises 1 cycle after accept; 3 words 8'hFF; out_last only on the 3rd.
- Token {SEXT, data=4'hA, count=0}, then {ZEXT, data=4'hA, count=0} back-to-back -> 8'hFA (last=1) then 8'h0A (last=1) on consecutive cycles, no bubble.
- Token {ZERO, count=15}, out_ready toggling 1/0 each cycle -> exactly 16 beats of 8'h00; data and last stable while stalled; in_ready=0 until the 16th beat.
- Token {SEXT, data=4'h7, count=1} while a second token is held valid -> 8'h07 twice; second token accepted only on the last-word beat.
- rst_n pulsed low during the 2nd word of {ONES, count=5} -> out_valid=0 asynchronously; after release, no further words until a new token.
- Idle: in_valid=0 for 10 cycles -> out_valid stays 0 and in_ready stays 1.
